// File: rtl/gold_nic.sv
// NIC between a processing element and its router PE port: a register window on
// the processor side, a single-entry input buffer and a VC-gated output FIFO on the network side.
module gold_nic #(
    parameter int DW        = 64,
    parameter int OUT_DEPTH = 2,
    parameter int VC_BIT    = 63
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [1:0]    addr,
    input  logic [DW-1:0] d_in,
    output logic [DW-1:0] d_out,
    input  logic          nicEn,
    input  logic          nicEnWr,
    input  logic          net_si,
    output logic          net_ri,
    input  logic [DW-1:0] net_di,
    output logic          net_so,
    input  logic          net_ro,
    output logic [DW-1:0] net_do,
    input  logic          net_polarity
);

    localparam int PW = $clog2(OUT_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(OUT_DEPTH);

    logic [DW-1:0] fifo_q [OUT_DEPTH];

    logic [DW-1:0] in_buf_q, in_buf_d;
    logic          in_full_q, in_full_d;
    logic [DW-1:0] d_out_q, d_out_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic          out_full;
    logic          wr_acc;
    logic          rd_req;
    logic          in_take;
    logic [DW-1:0] head;

    assign out_full = (count_q == FULL_CNT);
    assign head     = fifo_q[rd_ptr_q];
    assign net_do   = head;
    assign net_ri   = ~in_full_q;
    assign d_out    = d_out_q;

    // Inject only in the phase where the router writes the matching input VC.
    assign net_so = (count_q != '0) & net_ro & (head[VC_BIT] == ~net_polarity);

    assign wr_acc  = nicEn & nicEnWr & (addr == 2'b10) & ~out_full;
    assign rd_req  = nicEn & ~nicEnWr;
    assign in_take = net_si & ~in_full_q;

    always_comb begin
        in_buf_d  = in_buf_q;
        in_full_d = in_full_q;
        d_out_d   = d_out_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;

        if (rd_req) begin
            case (addr)
                2'b00: begin
                    d_out_d   = in_buf_q;
                    in_full_d = 1'b0;
                end
                2'b01:   d_out_d = {{(DW-1){1'b0}}, in_full_q};
                2'b11:   d_out_d = {{(DW-1){1'b0}}, out_full};
                default: d_out_d = '0;
            endcase
        end

        // An arrival while empty overrides a simultaneous (no-op) read-clear.
        if (in_take) begin
            in_buf_d  = net_di;
            in_full_d = 1'b1;
        end

        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (net_so) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        count_d = count_q + CW'(wr_acc) - CW'(net_so);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            in_buf_q  <= '0;
            in_full_q <= 1'b0;
            d_out_q   <= '0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            in_buf_q  <= in_buf_d;
            in_full_q <= in_full_d;
            d_out_q   <= d_out_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
        end
    end

    // Payload storage needs no reset; occupancy is tracked by count_q.
    always_ff @(posedge clk) begin
        if (reset && wr_acc) begin
            fifo_q[wr_ptr_q] <= d_in;
        end
    end

endmodule

// File: tb/tb_gold_nic.sv
// Table-driven bench for gold_nic; sent packets are checked against a scoreboard
// filled from accepted processor writes.
module tb_gold_nic;

    logic        clk;
    logic        reset;
    logic [1:0]  addr;
    logic [63:0] d_in;
    logic [63:0] d_out;
    logic        nicEn;
    logic        nicEnWr;
    logic        net_si;
    logic        net_ri;
    logic [63:0] net_di;
    logic        net_so;
    logic        net_ro;
    logic [63:0] net_do;
    logic        net_polarity;

    gold_nic #(.DW(64), .OUT_DEPTH(2), .VC_BIT(63)) dut (
        .clk(clk), .reset(reset), .addr(addr), .d_in(d_in), .d_out(d_out),
        .nicEn(nicEn), .nicEnWr(nicEnWr), .net_si(net_si), .net_ri(net_ri),
        .net_di(net_di), .net_so(net_so), .net_ro(net_ro), .net_do(net_do),
        .net_polarity(net_polarity)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          rst_n;
        bit          en;
        bit          wr;
        logic [1:0]  ad;
        logic [63:0] din;
        bit          si;
        logic [63:0] di;
        bit          ro;
        bit          pol;
        bit          acc;
        bit          exp_ri;
        bit          exp_so;
        logic [63:0] exp_dout;
    } vec_t;

    vec_t        tbl[$];
    logic [63:0] sb[$];
    int          passed = 0;
    int          total  = 0;

    localparam logic [63:0] PIN  = 64'hDEAD_BEEF_0000_0001;
    localparam logic [63:0] PE0  = 64'h0000_0000_0000_00E0;
    localparam logic [63:0] PO1  = 64'h8000_0000_0000_0001;
    localparam logic [63:0] PA   = 64'h0000_0000_0000_000A;
    localparam logic [63:0] PB   = 64'h0000_0000_0000_000B;
    localparam logic [63:0] PC   = 64'h0000_0000_0000_000C;
    localparam logic [63:0] PD1  = 64'h0000_0000_0000_00D1;
    localparam logic [63:0] PD2  = 64'h0000_0000_0000_00D2;
    localparam logic [63:0] PD3  = 64'h0000_0000_0000_00D3;
    localparam logic [63:0] PD4  = 64'h0000_0000_0000_00D4;
    localparam logic [63:0] PD5  = 64'h0000_0000_0000_00D5;
    localparam logic [63:0] PD6  = 64'h0000_0000_0000_00D6;

    function automatic vec_t V(bit rst_n, bit en, bit wr, logic [1:0] ad, logic [63:0] din,
                               bit si, logic [63:0] di, bit ro, bit pol, bit acc,
                               bit ri, bit so, logic [63:0] dout);
        vec_t v;
        v.rst_n = rst_n; v.en = en; v.wr = wr; v.ad = ad; v.din = din;
        v.si = si; v.di = di; v.ro = ro; v.pol = pol; v.acc = acc;
        v.exp_ri = ri; v.exp_so = so; v.exp_dout = dout;
        return v;
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end else begin
            passed++;
        end
    endtask

    // Called at posedge+1: drive, sample combinational outputs mid-cycle, then d_out after the edge.
    task automatic apply(input int idx, input vec_t v);
        logic [63:0] exp_pkt;
        reset        = v.rst_n;
        nicEn        = v.en;
        nicEnWr      = v.wr;
        addr         = v.ad;
        d_in         = v.din;
        net_si       = v.si;
        net_di       = v.di;
        net_ro       = v.ro;
        net_polarity = v.pol;
        if (v.acc) sb.push_back(v.din);
        #4;
        check($sformatf("v%0d net_ri", idx), {63'd0, net_ri}, {63'd0, v.exp_ri});
        check($sformatf("v%0d net_so", idx), {63'd0, net_so}, {63'd0, v.exp_so});
        if (net_so === 1'b1) begin
            if (sb.size() == 0) begin
                check($sformatf("v%0d sb_underflow", idx), net_do, 64'hX);
            end else begin
                exp_pkt = sb.pop_front();
                check($sformatf("v%0d net_do", idx), net_do, exp_pkt);
            end
        end
        @(posedge clk);
        #1;
        check($sformatf("v%0d d_out", idx), d_out, v.exp_dout);
        if (!v.rst_n) sb.delete();
        $display("vec %0d: rst_n=%0b en=%0b wr=%0b addr=%0d si=%0b ro=%0b pol=%0b so=%0b net_do=%h d_out=%h",
                 idx, v.rst_n, v.en, v.wr, v.ad, v.si, v.ro, v.pol, net_so, net_do, d_out);
    endtask

    initial begin
        int n;
        reset = 1'b0; nicEn = 1'b0; nicEnWr = 1'b0; addr = 2'b00; d_in = '0;
        net_si = 1'b0; net_di = '0; net_ro = 1'b0; net_polarity = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        //                rst en wr ad     din     si di                    ro pol acc ri so dout
        // reset state, input buffer path
        tbl.push_back(V(1, 0, 0, 2'b00, 64'd0,   0, 64'd0,                0, 0, 0,  1, 0, 64'd0));
        tbl.push_back(V(1, 1, 0, 2'b01, 64'd0,   0, 64'd0,                0, 0, 0,  1, 0, 64'd0));
        tbl.push_back(V(1, 1, 0, 2'b11, 64'd0,   0, 64'd0,                0, 0, 0,  1, 0, 64'd0));
        tbl.push_back(V(1, 0, 0, 2'b00, 64'd0,   1, PIN,                  0, 0, 0,  1, 0, 64'd0));
        tbl.push_back(V(1, 0, 0, 2'b00, 64'd0,   1, 64'h1111_2222_3333_4444, 0, 0, 0, 0, 0, 64'd0));
        tbl.push_back(V(1, 1, 0, 2'b01, 64'd0,   0, 64'd0,                0, 0, 0,  0, 0, 64'd1));
        tbl.push_back(V(1, 1, 0, 2'b00, 64'd0,   0, 64'd0,                0, 0, 0,  0, 0, PIN));
        tbl.push_back(V(1, 0, 0, 2'b00, 64'd0,   0, 64'd0,                0, 0, 0,  1, 0, PIN));
        tbl.push_back(V(1, 1, 0, 2'b00, 64'd0,   0, 64'd0,                0, 0, 0,  1, 0, PIN));
        tbl.push_back(V(1, 1, 0, 2'b10, 64'd0,   0, 64'd0,                0, 0, 0,  1, 0, 64'd0));
        tbl.push_back(V(1, 1, 1, 2'b00, 64'hFFFF, 0, 64'd0,               0, 0, 0,  1, 0, 64'd0));
        tbl.push_back(V(1, 1, 0, 2'b01, 64'd0,   0, 64'd0,                0, 0, 0,  1, 0, 64'd0));
        // VC gating: even packet leaves on polarity 1, odd on polarity 0
        tbl.push_back(V(1, 1, 1, 2'b10, PE0,     0, 64'd0,                1, 0, 1,  1, 0, 64'd0));
        tbl.push_back(V(1, 0, 0, 2'b00, 64'd0,   0, 64'd0,                1, 0, 0,  1, 0, 64'd0));
        tbl.push_back(V(1, 0, 0, 2'b00, 64'd0,   0, 64'd0,                1, 0, 0,  1, 0, 64'd0));
        tbl.push_back(V(1, 0, 0, 2'b00, 64'd0,   0, 64'd0,                1, 1, 0,  1, 1, 64'd0));
        tbl.push_back(V(1, 0, 0, 2'b00, 64'd0,   0, 64'd0,                1, 1, 0,  1, 0, 64'd0));
        tbl.push_back(V(1, 1, 1, 2'b10, PO1,     0, 64'd0,                1, 1, 1,  1, 0, 64'd0));
        tbl.push_back(V(1, 0, 0, 2'b00, 64'd0,   0, 64'd0,                1, 1, 0,  1, 0, 64'd0));
        tbl.push_back(V(1, 0, 0, 2'b00, 64'd0,   0, 64'd0,                1, 0, 0,  1, 1, 64'd0));
        tbl.push_back(V(1, 0, 0, 2'b00, 64'd0,   0, 64'd0,                1, 0, 0,  1, 0, 64'd0));
        // FIFO full, drop and wrap
        tbl.push_back(V(1, 1, 1, 2'b10, PA,      0, 64'd0,                0, 1, 1,  1, 0, 64'd0));
        tbl.push_back(V(1, 1, 1, 2'b10, PB,      0, 64'd0,                0, 1, 1,  1, 0, 64'd0));
        tbl.push_back(V(1, 1, 1, 2'b10, PC,      0, 64'd0,                0, 1, 0,  1, 0, 64'd0));
        tbl.push_back(V(1, 1, 0, 2'b11, 64'd0,   0, 64'd0,                0, 1, 0,  1, 0, 64'd1));
        tbl.push_back(V(1, 0, 0, 2'b00, 64'd0,   0, 64'd0,                1, 1, 0,  1, 1, 64'd1));
        tbl.push_back(V(1, 0, 0, 2'b00, 64'd0,   0, 64'd0,                1, 1, 0,  1, 1, 64'd1));
        tbl.push_back(V(1, 1, 0, 2'b11, 64'd0,   0, 64'd0,                0, 1, 0,  1, 0, 64'd0));
        tbl.push_back(V(1, 1, 1, 2'b10, PD1,     0, 64'd0,                0, 1, 1,  1, 0, 64'd0));
        tbl.push_back(V(1, 1, 1, 2'b10, PD2,     0, 64'd0,                0, 1, 1,  1, 0, 64'd0));
        tbl.push_back(V(1, 0, 0, 2'b00, 64'd0,   0, 64'd0,                1, 1, 0,  1, 1, 64'd0));
        // simultaneous write and send: accepted when not full, dropped when full
        tbl.push_back(V(1, 1, 1, 2'b10, PD3,     0, 64'd0,                1, 1, 1,  1, 1, 64'd0));
        tbl.push_back(V(1, 1, 1, 2'b10, PD4,     0, 64'd0,                0, 1, 1,  1, 0, 64'd0));
        tbl.push_back(V(1, 1, 1, 2'b10, PD5,     0, 64'd0,                1, 1, 0,  1, 1, 64'd0));
        tbl.push_back(V(1, 1, 0, 2'b11, 64'd0,   0, 64'd0,                0, 1, 0,  1, 0, 64'd0));

        n = 0;
        for (int i = 0; i < tbl.size(); i++) begin
            apply(n, tbl[i]);
            n++;
        end

        // backpressure: D4 must stay at the head for 10 cycles, then leave intact
        for (int i = 0; i < 10; i++) begin
            apply(n, V(1, 0, 0, 2'b00, 64'd0, 0, 64'd0, 0, 1, 0, 1, 0, 64'd0));
            n++;
        end
        apply(n, V(1, 0, 0, 2'b00, 64'd0, 0, 64'd0, 1, 1, 0, 1, 1, 64'd0)); n++;

        // reset mid-traffic drops the queued packet and the buffered input
        apply(n, V(1, 1, 1, 2'b10, PD6,   1, 64'h77, 0, 1, 1, 1, 0, 64'd0)); n++;
        apply(n, V(1, 1, 0, 2'b01, 64'd0, 0, 64'd0,  0, 1, 0, 0, 0, 64'd1)); n++;
        apply(n, V(0, 1, 0, 2'b11, 64'd0, 1, 64'h99, 0, 1, 0, 0, 0, 64'd0)); n++;
        apply(n, V(0, 1, 0, 2'b01, 64'd0, 1, 64'h99, 0, 1, 0, 1, 0, 64'd0)); n++;
        apply(n, V(1, 0, 0, 2'b00, 64'd0, 0, 64'd0,  1, 1, 0, 1, 0, 64'd0)); n++;
        apply(n, V(1, 1, 0, 2'b01, 64'd0, 0, 64'd0,  1, 1, 0, 1, 0, 64'd0)); n++;
        apply(n, V(1, 1, 0, 2'b11, 64'd0, 0, 64'd0,  1, 1, 0, 1, 0, 64'd0)); n++;
        apply(n, V(1, 1, 0, 2'b00, 64'd0, 0, 64'd0,  1, 1, 0, 1, 0, 64'd0)); n++;

        check("sb_empty", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
